// File: rtl/trap_irq_ctrl_if.sv
// Trap controller bus: pipeline-side requests and CSR access
// towards the controller, redirect and CSR state back.
interface trap_irq_ctrl_if #(
   parameter int XLEN    = 32,
   parameter int NUM_EXC = 4,
   parameter int NUM_IRQ = 2
);
   logic [NUM_EXC-1:0] exc_req;
   logic [XLEN-1:0]    exc_pc;
   logic [XLEN-1:0]    exc_tval;
   logic [NUM_IRQ-1:0] irq_in;
   logic               retire_valid;
   logic [XLEN-1:0]    retire_pc;
   logic               pipe_stall;
   logic               mret;
   logic               csr_we;
   logic [1:0]         csr_addr;
   logic [XLEN-1:0]    csr_wdata;
   logic               redirect_valid;
   logic [XLEN-1:0]    redirect_pc;
   logic [XLEN-1:0]    mcause;
   logic [XLEN-1:0]    mepc;
   logic [XLEN-1:0]    mtval;
   logic [XLEN-1:0]    mtvec;
   logic [NUM_IRQ-1:0] mie_mask;
   logic               mstatus_mie;
   logic [NUM_IRQ-1:0] irq_pending;
   logic [1:0]         privilege;

   modport slave (
      input  exc_req, exc_pc, exc_tval, irq_in,
      input  retire_valid, retire_pc, pipe_stall, mret,
      input  csr_we, csr_addr, csr_wdata,
      output redirect_valid, redirect_pc, mcause, mepc,
      output mtval, mtvec, mie_mask, mstatus_mie,
      output irq_pending, privilege
   );

   modport master (
      output exc_req, exc_pc, exc_tval, irq_in,
      output retire_valid, retire_pc, pipe_stall, mret,
      output csr_we, csr_addr, csr_wdata,
      input  redirect_valid, redirect_pc, mcause, mepc,
      input  mtval, mtvec, mie_mask, mstatus_mie,
      input  irq_pending, privilege
   );
endinterface

// File: rtl/trap_irq_ctrl.sv
// Machine-mode trap/interrupt controller: prioritised exceptions,
// synchronised interrupts, mret, vectored mtvec and PC redirect.
module trap_irq_ctrl #(
   parameter int XLEN        = 32,
   parameter int NUM_EXC     = 4,
   parameter int NUM_IRQ     = 2,
   parameter int SYNC_STAGES = 2
) (
   input logic           clk,
   input logic           reset,
   trap_irq_ctrl_if.slave bus
);

   typedef enum logic {IDLE, REDIRECT} state_t;

   localparam logic [1:0] PRIV_M = 2'b11;

   state_t             state;
   logic               mpie;
   logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];
   logic [NUM_IRQ-1:0] sync_d;
   logic [NUM_IRQ-1:0] rise;
   logic [NUM_IRQ-1:0] irq_hit;
   logic [NUM_IRQ-1:0] irq_clr;
   logic [XLEN-1:0]    exc_code;
   logic [XLEN-1:0]    irq_code;
   logic [XLEN-1:0]    base;
   logic [XLEN-1:0]    irq_target;
   logic               take_exc;
   logic               take_mret;
   logic               take_irq;

   // irq_in synchroniser chain plus one delay flop for edge detect
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < SYNC_STAGES; i++)
            sync_q[i] <= '0;
         sync_d <= '0;
      end else begin
         sync_q[0] <= bus.irq_in;
         for (int i = 1; i < SYNC_STAGES; i++)
            sync_q[i] <= sync_q[i-1];
         sync_d <= sync_q[SYNC_STAGES-1];
      end
   end

   assign rise = sync_q[SYNC_STAGES-1] & ~sync_d;

   // lowest-index exception wins; cause code is index + 1
   always_comb begin
      exc_code = '0;
      for (int i = NUM_EXC - 1; i >= 0; i--)
         if (bus.exc_req[i])
            exc_code = XLEN'(i + 1);
   end

   // lowest-index enabled pending interrupt wins
   always_comb begin
      irq_hit  = bus.irq_pending & bus.mie_mask;
      irq_clr  = '0;
      irq_code = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--)
         if (irq_hit[i]) begin
            irq_clr    = '0;
            irq_clr[i] = 1'b1;
            irq_code   = XLEN'(16 + i);
         end
   end

   // event qualification; REDIRECT ignores flushed requests
   always_comb begin
      take_exc  = (state == IDLE) && (|bus.exc_req);
      take_mret = (state == IDLE) && !take_exc && bus.mret;
      take_irq  = (state == IDLE) && !take_exc && !bus.mret
                  && bus.mstatus_mie && (|irq_hit)
                  && bus.retire_valid && !bus.pipe_stall;
      base       = {bus.mtvec[XLEN-1:2], 2'b00};
      irq_target = (bus.mtvec[1:0] == 2'b01)
                   ? base + (irq_code << 2) : base;
   end

   // FSM, CSR file and pending latches; trap updates override
   // a same-cycle CSR write to the register they touch
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state              <= IDLE;
         bus.redirect_valid <= 1'b0;
         bus.redirect_pc    <= '0;
         bus.mcause         <= '0;
         bus.mepc           <= '0;
         bus.mtval          <= '0;
         bus.mtvec          <= '0;
         bus.mie_mask       <= '0;
         bus.mstatus_mie    <= 1'b0;
         mpie               <= 1'b0;
         bus.irq_pending    <= '0;
         bus.privilege      <= PRIV_M;
      end else begin
         state              <= IDLE;
         bus.redirect_valid <= 1'b0;
         bus.irq_pending    <= (bus.irq_pending
                                & ~(take_irq ? irq_clr : '0))
                               | rise;
         if (bus.csr_we) begin
            case (bus.csr_addr)
               2'd0: begin
                  bus.mstatus_mie <= bus.csr_wdata[3];
                  mpie            <= bus.csr_wdata[7];
               end
               2'd1: bus.mtvec <= bus.csr_wdata;
               2'd2: bus.mie_mask <= bus.csr_wdata[NUM_IRQ-1:0];
               default:
                  bus.mepc <= {bus.csr_wdata[XLEN-1:2], 2'b00};
            endcase
         end
         if (take_exc) begin
            state              <= REDIRECT;
            bus.redirect_valid <= 1'b1;
            bus.redirect_pc    <= base;
            bus.mcause         <= exc_code;
            bus.mepc           <= bus.exc_pc;
            bus.mtval          <= bus.exc_tval;
            mpie               <= bus.mstatus_mie;
            bus.mstatus_mie    <= 1'b0;
            bus.privilege      <= PRIV_M;
         end else if (take_mret) begin
            state              <= REDIRECT;
            bus.redirect_valid <= 1'b1;
            bus.redirect_pc    <= bus.mepc;
            bus.mstatus_mie    <= mpie;
            mpie               <= 1'b1;
            bus.privilege      <= PRIV_M;
         end else if (take_irq) begin
            state              <= REDIRECT;
            bus.redirect_valid <= 1'b1;
            bus.redirect_pc    <= irq_target;
            bus.mcause         <= {1'b1, irq_code[XLEN-2:0]};
            bus.mepc           <= bus.retire_pc;
            bus.mtval          <= '0;
            mpie               <= bus.mstatus_mie;
            bus.mstatus_mie    <= 1'b0;
            bus.privilege      <= PRIV_M;
         end
      end
   end

endmodule

// File: tb/tb_trap_irq_ctrl.sv
// Scenario bench for trap_irq_ctrl: expected redirects are queued
// when stimulus is applied and compared when the redirect appears.
module tb_trap_irq_ctrl;

   localparam int XLEN = 32;
   localparam int NE   = 4;
   localparam int NI   = 2;
   localparam int SS   = 2;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] cause;
      logic [31:0] epc;
      logic [31:0] tval;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int checks = 0;
   int failures = 0;
   exp_t sb[$];
   exp_t e;

   trap_irq_ctrl_if #(.XLEN(XLEN), .NUM_EXC(NE), .NUM_IRQ(NI)) bus ();

   trap_irq_ctrl #(
      .XLEN(XLEN), .NUM_EXC(NE), .NUM_IRQ(NI), .SYNC_STAGES(SS)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic wait_redirect(input int budget, output bit seen);
      seen = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (bus.redirect_valid) begin
            seen = 1'b1;
            break;
         end
      end
   endtask

   task automatic csr_write(input logic [1:0] a, input logic [31:0] d);
      @(negedge clk);
      bus.csr_we    = 1'b1;
      bus.csr_addr  = a;
      bus.csr_wdata = d;
      @(negedge clk);
      bus.csr_we = 1'b0;
   endtask

   task automatic test_reset();
      bus.exc_req = '0; bus.exc_pc = '0; bus.exc_tval = '0;
      bus.irq_in = '0; bus.retire_valid = 0; bus.retire_pc = '0;
      bus.pipe_stall = 0; bus.mret = 0; bus.csr_we = 0;
      bus.csr_addr = '0; bus.csr_wdata = '0;
      reset = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({bus.redirect_valid, bus.privilege, bus.mtvec, bus.mcause,
           bus.irq_pending, bus.mstatus_mie} !== {1'b0, 2'b11, 32'h0,
           32'h0, 2'b00, 1'b0}) begin
         failures++;
         $display("FAIL reset_state got rv=%b priv=%b mtvec=%h mcause=%h",
                  bus.redirect_valid, bus.privilege, bus.mtvec, bus.mcause);
      end
      reset = 1'b1;
   endtask

   task automatic test_csr();
      csr_write(2'd1, 32'h200);
      csr_write(2'd3, 32'h123);
      checks++;
      if (bus.mtvec !== 32'h200) begin
         failures++;
         $display("FAIL csr_mtvec got=%h exp=%h", bus.mtvec, 32'h200);
      end
      checks++;
      if (bus.mepc !== 32'h120) begin
         failures++;
         $display("FAIL csr_mepc_align got=%h exp=%h", bus.mepc, 32'h120);
      end
   endtask

   task automatic test_exception();
      bit seen;
      csr_write(2'd0, 32'h8);
      checks++;
      if (bus.mstatus_mie !== 1'b1) begin
         failures++;
         $display("FAIL csr_mstatus got=%b exp=1", bus.mstatus_mie);
      end
      bus.exc_req = 4'b1010; bus.exc_pc = 32'h100; bus.exc_tval = 32'h33;
      sb.push_back('{32'h200, 32'd2, 32'h100, 32'h33});
      wait_redirect(1, seen);
      bus.exc_req = '0;
      checks++;
      if (!seen) begin
         failures++;
         $display("FAIL exc_latency got=no_redirect exp=redirect");
      end else begin
         e = sb.pop_front();
         checks++;
         if ({bus.redirect_pc, bus.mcause, bus.mepc, bus.mtval}
             !== {e.pc, e.cause, e.epc, e.tval}) begin
            failures++;
            $display("FAIL exc_redirect got=%h/%h/%h/%h exp=%h/%h/%h/%h",
                     bus.redirect_pc, bus.mcause, bus.mepc, bus.mtval,
                     e.pc, e.cause, e.epc, e.tval);
         end
         checks++;
         if (bus.mstatus_mie !== 1'b0) begin
            failures++;
            $display("FAIL exc_mie got=%b exp=0", bus.mstatus_mie);
         end
      end
      @(negedge clk);
      checks++;
      if (bus.redirect_valid !== 1'b0) begin
         failures++;
         $display("FAIL exc_one_cycle got=%b exp=0", bus.redirect_valid);
      end
   endtask

   task automatic test_irq_vectored();
      bit seen;
      csr_write(2'd0, 32'h8);
      csr_write(2'd1, 32'h201);
      csr_write(2'd2, 32'h3);
      bus.retire_valid = 1; bus.retire_pc = 32'h40; bus.irq_in = 2'b11;
      sb.push_back('{32'h240, 32'h8000_0010, 32'h40, 32'h0});
      wait_redirect(SS + 6, seen);
      bus.retire_valid = 0;
      checks++;
      if (!seen) begin
         failures++;
         $display("FAIL irq_timeout got=no_redirect exp=redirect");
      end else begin
         e = sb.pop_front();
         checks++;
         if ({bus.redirect_pc, bus.mcause, bus.mepc, bus.mtval}
             !== {e.pc, e.cause, e.epc, e.tval}) begin
            failures++;
            $display("FAIL irq_redirect got=%h/%h/%h/%h exp=%h/%h/%h/%h",
                     bus.redirect_pc, bus.mcause, bus.mepc, bus.mtval,
                     e.pc, e.cause, e.epc, e.tval);
         end
         checks++;
         if (bus.irq_pending !== 2'b10) begin
            failures++;
            $display("FAIL irq_pending got=%b exp=10", bus.irq_pending);
         end
      end
   endtask

   task automatic test_mret_then_irq1();
      bit seen;
      repeat (2) @(negedge clk);
      bus.irq_in = 2'b00;
      bus.mret = 1;
      sb.push_back('{32'h40, 32'h8000_0010, 32'h40, 32'h0});
      wait_redirect(1, seen);
      bus.mret = 0;
      checks++;
      if (!seen) begin
         failures++;
         $display("FAIL mret_latency got=no_redirect exp=redirect");
      end else begin
         e = sb.pop_front();
         checks++;
         if ({bus.redirect_pc, bus.mstatus_mie} !== {e.pc, 1'b1}) begin
            failures++;
            $display("FAIL mret_return got=%h/%b exp=%h/1",
                     bus.redirect_pc, bus.mstatus_mie, e.pc);
         end
      end
      bus.retire_valid = 1; bus.retire_pc = 32'h80;
      sb.push_back('{32'h244, 32'h8000_0011, 32'h80, 32'h0});
      wait_redirect(4, seen);
      bus.retire_valid = 0;
      checks++;
      if (!seen) begin
         failures++;
         $display("FAIL irq1_timeout got=no_redirect exp=redirect");
      end else begin
         e = sb.pop_front();
         checks++;
         if ({bus.redirect_pc, bus.mcause, bus.mepc, bus.irq_pending}
             !== {e.pc, e.cause, e.epc, 2'b00}) begin
            failures++;
            $display("FAIL irq1_redirect got=%h/%h/%h/%b exp=%h/%h/%h/00",
                     bus.redirect_pc, bus.mcause, bus.mepc,
                     bus.irq_pending, e.pc, e.cause, e.epc);
         end
      end
   endtask

   task automatic test_stall();
      bit seen;
      int spurious;
      csr_write(2'd0, 32'h8);
      repeat (SS + 2) @(negedge clk);
      bus.pipe_stall = 1; bus.retire_valid = 1; bus.retire_pc = 32'h90;
      bus.irq_in = 2'b01;
      spurious = 0;
      for (int i = 0; i < SS + 8; i++) begin
         @(negedge clk);
         if (bus.redirect_valid) spurious++;
      end
      checks++;
      if (spurious != 0 || bus.irq_pending !== 2'b01) begin
         failures++;
         $display("FAIL stall_hold got=%0d/%b exp=0/01",
                  spurious, bus.irq_pending);
      end
      bus.pipe_stall = 0;
      sb.push_back('{32'h240, 32'h8000_0010, 32'h90, 32'h0});
      wait_redirect(1, seen);
      bus.retire_valid = 0; bus.irq_in = 2'b00;
      checks++;
      if (!seen) begin
         failures++;
         $display("FAIL stall_release got=no_redirect exp=redirect");
      end else begin
         e = sb.pop_front();
         checks++;
         if ({bus.redirect_pc, bus.mcause, bus.mepc}
             !== {e.pc, e.cause, e.epc}) begin
            failures++;
            $display("FAIL stall_redirect got=%h/%h/%h exp=%h/%h/%h",
                     bus.redirect_pc, bus.mcause, bus.mepc,
                     e.pc, e.cause, e.epc);
         end
      end
   endtask

   task automatic test_exc_vs_mret();
      bit seen;
      @(negedge clk);
      bus.exc_req = 4'b0001; bus.exc_pc = 32'h300; bus.exc_tval = 32'h44;
      bus.mret = 1;
      bus.csr_we = 1; bus.csr_addr = 2'd3; bus.csr_wdata = 32'h500;
      sb.push_back('{32'h200, 32'd1, 32'h300, 32'h44});
      wait_redirect(1, seen);
      bus.exc_req = '0; bus.mret = 0; bus.csr_we = 0;
      checks++;
      if (!seen) begin
         failures++;
         $display("FAIL excmret_latency got=no_redirect exp=redirect");
      end else begin
         e = sb.pop_front();
         checks++;
         if ({bus.redirect_pc, bus.mcause, bus.mepc, bus.mtval}
             !== {e.pc, e.cause, e.epc, e.tval}) begin
            failures++;
            $display("FAIL excmret_redirect got=%h/%h/%h/%h exp=%h/%h/%h/%h",
                     bus.redirect_pc, bus.mcause, bus.mepc, bus.mtval,
                     e.pc, e.cause, e.epc, e.tval);
         end
      end
      @(negedge clk);
      bus.mret = 1;
      sb.push_back('{32'h300, 32'd1, 32'h300, 32'h44});
      wait_redirect(1, seen);
      bus.mret = 0;
      checks++;
      if (!seen) begin
         failures++;
         $display("FAIL nested_mret_latency got=no_redirect exp=redirect");
      end else begin
         e = sb.pop_front();
         checks++;
         if ({bus.redirect_pc, bus.mstatus_mie} !== {e.pc, 1'b0}) begin
            failures++;
            $display("FAIL nested_mpie got=%h/%b exp=%h/0",
                     bus.redirect_pc, bus.mstatus_mie, e.pc);
         end
      end
   endtask

   task automatic test_reset_mid_redirect();
      bit seen;
      @(negedge clk);
      bus.exc_req = 4'b0100; bus.exc_pc = 32'h10; bus.exc_tval = 32'h0;
      sb.push_back('{32'h200, 32'd3, 32'h10, 32'h0});
      wait_redirect(1, seen);
      bus.exc_req = '0;
      checks++;
      if (!seen) begin
         failures++;
         $display("FAIL rst_mid_setup got=no_redirect exp=redirect");
      end else begin
         e = sb.pop_front();
         checks++;
         if (bus.mcause !== e.cause) begin
            failures++;
            $display("FAIL rst_mid_cause got=%h exp=%h", bus.mcause, e.cause);
         end
      end
      reset = 1'b0;
      #1;
      checks++;
      if ({bus.redirect_valid, bus.privilege, bus.mtvec, bus.mepc,
           bus.mcause, bus.mtval, bus.mie_mask, bus.mstatus_mie,
           bus.redirect_pc} !== {1'b0, 2'b11, 32'h0, 32'h0, 32'h0,
           32'h0, 2'b00, 1'b0, 32'h0}) begin
         failures++;
         $display("FAIL rst_mid_state got rv=%b priv=%b mtvec=%h mepc=%h mcause=%h",
                  bus.redirect_valid, bus.privilege, bus.mtvec,
                  bus.mepc, bus.mcause);
      end
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_csr();
      test_exception();
      test_irq_vectored();
      test_mret_then_irq1();
      test_stall();
      test_exc_vs_mret();
      test_reset_mid_redirect();
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain got=%0d exp=0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
